// File: rtl/ifid_queue_pkg.sv
// ============================================================================
// ifid_queue_pkg : shared widths and the bubble instruction for the IF/ID queue
// Revision 1.0
// ============================================================================
`default_nettype none

package ifid_queue_pkg;
  localparam int          REG_W    = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] ZERO32   = 32'h0000_0000;
endpackage

`default_nettype wire

// File: rtl/ifid_fifo_mem.sv
// ============================================================================
// ifid_fifo_mem : circular storage with pointers and occupancy count
// Revision 1.0
// ============================================================================
`default_nettype none

module ifid_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pointers wrap by overflow; occupancy alone decides full/empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/ifid_queue.sv
// ============================================================================
// ifid_queue : DEPTH-entry IF/ID instruction queue with registered ID output
// Revision 1.0
// ============================================================================
`default_nettype none

module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int                INST_W      = REG_W,
  parameter int                ADDR_W      = REG_W,
  parameter int                DEPTH       = 4,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(NOP_INST)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       id_stall,
  input  logic                       if_valid_in,
  input  logic [INST_W-1:0]          if_inst_in,
  input  logic [ADDR_W-1:0]          if_addr_in,
  output logic                       if_ready_out,
  output logic                       ifid_valid_out,
  output logic [INST_W-1:0]          ifid_inst_out,
  output logic [ADDR_W-1:0]          ifid_addr_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DATA_W = INST_W + ADDR_W;

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              have_head, ready, push, pop, fifo_push, fifo_pop;

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  ifid_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({if_inst_in, if_addr_in}),
    .rd_data (head),
    .count   (count)
  );

  always_comb begin
    have_head = (count != '0);
    ready     = (count < CNT_W'(DEPTH));
    push      = if_valid_in & ready;
    pop       = !id_stall;
    // An empty queue hands the push straight to the output register.
    fifo_push = push & !(pop & !have_head) & !flush;
    fifo_pop  = pop & have_head & !flush;

    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = BUBBLE_INST;
      addr_d  = ADDR_W'(ZERO32);
    end else if (pop) begin
      if (have_head) begin
        valid_d = 1'b1;
        inst_d  = head[DATA_W-1:ADDR_W];
        addr_d  = head[ADDR_W-1:0];
      end else if (push) begin
        valid_d = 1'b1;
        inst_d  = if_inst_in;
        addr_d  = if_addr_in;
      end else begin
        valid_d = 1'b0;
        inst_d  = BUBBLE_INST;
        addr_d  = ADDR_W'(ZERO32);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= BUBBLE_INST;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
    end
  end

  assign if_ready_out   = ready;
  assign ifid_valid_out = valid_q;
  assign ifid_inst_out  = inst_q;
  assign ifid_addr_out  = addr_q;
  assign count_out      = count;

endmodule

`default_nettype wire

// File: tb/tb_ifid_queue.sv
// ============================================================================
// tb_ifid_queue : directed vector table plus randomized run against a queue model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ifid_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, id_stall, if_valid_in;
  logic [31:0] if_inst_in, if_addr_in;
  logic        if_ready_out, ifid_valid_out;
  logic [31:0] ifid_inst_out, ifid_addr_out;
  logic [2:0]  count_out;

  ifid_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BUBBLE_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .id_stall       (id_stall),
    .if_valid_in    (if_valid_in),
    .if_inst_in     (if_inst_in),
    .if_addr_in     (if_addr_in),
    .if_ready_out   (if_ready_out),
    .ifid_valid_out (ifid_valid_out),
    .ifid_inst_out  (ifid_inst_out),
    .ifid_addr_out  (ifid_addr_out),
    .count_out      (count_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: a plain queue of {inst,addr} plus the output register contents.
  logic [63:0] mq[$];
  logic        m_valid;
  logic [31:0] m_inst, m_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic f, input logic s,
                              input logic v, input logic [31:0] a);
    bit rdy, push;
    rdy  = (mq.size() < DEPTH);
    push = v && rdy;
    if (r || f) begin
      mq.delete();
      m_valid = 1'b0; m_inst = NOP; m_addr = '0;
    end else begin
      if (!s) begin
        if (mq.size() > 0) begin
          {m_inst, m_addr} = mq.pop_front();
          m_valid = 1'b1;
        end else if (push) begin
          m_inst = inst_of(a); m_addr = a; m_valid = 1'b1;
          push = 1'b0;
        end else begin
          m_valid = 1'b0; m_inst = NOP; m_addr = '0;
        end
      end
      if (push) mq.push_back({inst_of(a), a});
    end
  endtask

  task automatic drive_clock(input logic r, input logic f, input logic s,
                             input logic v, input logic [31:0] a);
    rst = r; flush = f; id_stall = s; if_valid_in = v;
    if_addr_in = a; if_inst_in = inst_of(a);
    @(posedge clk);
    #1;
    model_update(r, f, s, v, a);
  endtask

  task automatic step_model(input logic r, input logic f, input logic s,
                            input logic v, input logic [31:0] a);
    drive_clock(r, f, s, v, a);
    chk("valid", 32'(ifid_valid_out), 32'(m_valid));
    chk("inst",  ifid_inst_out, m_inst);
    chk("addr",  ifid_addr_out, m_addr);
    chk("count", 32'(count_out), 32'(mq.size()));
    chk("ready", 32'(if_ready_out), 32'(mq.size() < DEPTH));
  endtask

  typedef struct {
    logic        r, f, s, v;
    logic [31:0] a;
    logic        ev;
    logic [31:0] ea;
    int          ec;
    logic        er;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                              input logic [31:0] a, input logic ev, input logic [31:0] ea,
                              input int ec, input logic er);
    vec_t t;
    t.r = r; t.f = f; t.s = s; t.v = v; t.a = a;
    t.ev = ev; t.ea = ea; t.ec = ec; t.er = er;
    return t;
  endfunction

  vec_t tbl[29];

  initial begin
    rst = 1'b1; flush = 1'b0; id_stall = 1'b0; if_valid_in = 1'b0;
    if_inst_in = '0; if_addr_in = '0;
    m_valid = 1'b0; m_inst = NOP; m_addr = '0;

    //              r  f  s  v  addr    ev ea     cnt rdy
    tbl[0]  = mk(1, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1);
    tbl[1]  = mk(0, 0, 0, 1, 32'h00, 1, 32'h00, 0, 1);
    tbl[2]  = mk(0, 0, 0, 1, 32'h04, 1, 32'h04, 0, 1);
    tbl[3]  = mk(0, 0, 0, 1, 32'h08, 1, 32'h08, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1);
    tbl[6]  = mk(0, 0, 1, 1, 32'h10, 0, 32'h00, 1, 1);
    tbl[7]  = mk(0, 0, 1, 1, 32'h14, 0, 32'h00, 2, 1);
    tbl[8]  = mk(0, 0, 1, 1, 32'h18, 0, 32'h00, 3, 1);
    tbl[9]  = mk(0, 0, 1, 1, 32'h1C, 0, 32'h00, 4, 0);
    tbl[10] = mk(0, 0, 1, 1, 32'h20, 0, 32'h00, 4, 0);
    tbl[11] = mk(0, 0, 1, 1, 32'h20, 0, 32'h00, 4, 0);
    tbl[12] = mk(0, 0, 0, 1, 32'h20, 1, 32'h10, 3, 1);
    tbl[13] = mk(0, 0, 0, 1, 32'h20, 1, 32'h14, 3, 1);
    tbl[14] = mk(0, 0, 0, 0, 32'h00, 1, 32'h18, 2, 1);
    tbl[15] = mk(0, 0, 0, 0, 32'h00, 1, 32'h1C, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 32'h00, 1, 32'h20, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1);
    tbl[18] = mk(0, 0, 0, 1, 32'h40, 1, 32'h40, 0, 1);
    tbl[19] = mk(0, 0, 1, 1, 32'h44, 1, 32'h40, 1, 1);
    tbl[20] = mk(0, 0, 1, 1, 32'h48, 1, 32'h40, 2, 1);
    tbl[21] = mk(0, 0, 1, 1, 32'h4C, 1, 32'h40, 3, 1);
    tbl[22] = mk(0, 1, 1, 1, 32'h50, 0, 32'h00, 0, 1);
    tbl[23] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1);
    tbl[24] = mk(0, 0, 1, 1, 32'h60, 0, 32'h00, 1, 1);
    tbl[25] = mk(0, 0, 1, 1, 32'h64, 0, 32'h00, 2, 1);
    tbl[26] = mk(1, 0, 1, 1, 32'h68, 0, 32'h00, 0, 1);
    tbl[27] = mk(0, 0, 0, 1, 32'h70, 1, 32'h70, 0, 1);
    tbl[28] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1);

    for (int i = 0; i < 29; i++) begin
      drive_clock(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].a);
      chk($sformatf("t%0d_valid", i), 32'(ifid_valid_out), 32'(tbl[i].ev));
      chk($sformatf("t%0d_inst", i), ifid_inst_out, tbl[i].ev ? inst_of(tbl[i].ea) : NOP);
      chk($sformatf("t%0d_addr", i), ifid_addr_out, tbl[i].ea);
      chk($sformatf("t%0d_count", i), 32'(count_out), 32'(tbl[i].ec));
      chk($sformatf("t%0d_ready", i), 32'(if_ready_out), 32'(tbl[i].er));
    end

    // Hold two entries while streaming ten more through past the pointer wrap.
    step_model(0, 0, 1, 1, 32'h100);
    step_model(0, 0, 1, 1, 32'h104);
    for (int i = 0; i < 10; i++) begin
      step_model(0, 0, 0, 1, 32'h108 + 32'(i * 4));
      chk("wrap_count", 32'(count_out), 32'd2);
    end
    for (int i = 0; i < 3; i++) step_model(0, 0, 0, 0, 32'h0);

    // Randomized traffic checked against the reference queue.
    for (int i = 0; i < 400; i++) begin
      step_model(($urandom_range(0, 59) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7),
                 32'($urandom_range(0, 255)) << 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry instruction queue between fetch and decode, so fetch can run ahead while ID is stalled. It provides a registered decode-side output with an explicit valid bit, a configurable bubble instruction, a flush input for branch/jump redirect, and fetch-side backpressure. When empty, a push goes straight to the output, so the latency matches the old single register.

Parameters:
INST_W, 32, instruction width
ADDR_W, 32, PC width
DEPTH, 4, queue entries; power of two, >= 2
BUBBLE_INST, 32'h00000013, instruction driven when no valid instruction (RISC-V addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  discard all queued and output contents (redirect)
id_stall  in  1  decode stalled; hold output register
if_valid_in  in  1  fetch presents an instruction
if_inst_in  in  INST_W  fetched instruction
if_addr_in  in  ADDR_W  PC of fetched instruction
if_ready_out  out  1  queue can accept a push this cycle
ifid_valid_out  out  1  output register holds a real instruction
ifid_inst_out  out  INST_W  instruction to ID
ifid_addr_out  out  ADDR_W  PC to ID
count_out  out  $clog2(DEPTH+1)  entries stored, excluding the output register

Behaviour:
- One clock, clk. Synchronous active-high rst. All state updates on posedge clk.
- Reset values:
  - ifid_valid_out=0, ifid_inst_out=BUBBLE_INST, ifid_addr_out=0.
  - count_out=0, read/write pointers=0.
  - if_ready_out=1 in the cycle after reset.
- Priority: rst > flush > normal operation.
- flush:
  - Next cycle: count=0, pointers=0, output = bubble (valid=0, BUBBLE_INST, addr 0).
  - A push presented in the flush cycle is dropped. id_stall is ignored.
- Push: push = if_valid_in & if_ready_out.
  - if_ready_out = (count < DEPTH), from registered count only.
  - No same-cycle pop-frees-slot path, so full means not ready even if ID pops.
- Pop: pop = !id_stall. On pop, the output register loads:
  - the queue head, if count > 0 (valid=1, count decrements unless a push also occurs);
  - else the push data directly (bypass, valid=1), with nothing stored, if push occurs;
  - else a bubble (valid=0, BUBBLE_INST, addr 0).
- Stall: id_stall=1 holds the output register unchanged. Pushes still enqueue while count < DEPTH.
- Simultaneous push+pop with count>0: head goes to output, push goes to tail, count unchanged.
- Latency: empty queue, no stall gives 1 cycle push-to-output. Otherwise in FIFO order behind queued entries.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty come from count, not pointer compare.
- Order: program order preserved; no entry duplicated or lost except by flush.
- X-safety: storage contents need no reset. Outputs never expose unwritten storage because pop reads only when count>0.

Decomposition:
- Shared define.v additions: `nopInst (32'h00000013) and `zero32, reusing `regBus for default widths. No new typedefs.
- One sub-module: ifid_fifo_mem. It holds DEPTH×(INST_W+ADDR_W) storage, write/read pointers and count, with push/pop/clear inputs and head data output.
- ifid_queue keeps the output register, bypass mux and flush/stall priority logic.

Test Plan:
- Reset, then 3 consecutive pushes (PC 0x00,0x04,0x08), no stall -> output shows 0x00,0x04,0x08 on successive cycles, 1-cycle latency, count_out stays 0.
- Assert id_stall for 6 cycles while pushing 5 instructions, DEPTH=4:
  - count_out reaches 4 and if_ready_out=0; the 5th is held by fetch.
  - Output is frozen throughout.
  - Release stall -> all 5 appear in order, one per cycle.
- Queue at count=2, push+pop same cycle -> count_out stays 2, output = old head, FIFO order intact across pointer wrap (run 10 entries through).
- Flush with count=3, output valid, push and id_stall all asserted -> next cycle valid=0, inst=0x00000013, addr=0, count=0, pushed instruction absent.
- Empty queue, no push, no stall -> bubble every cycle: valid=0, inst=0x00000013.
- rst asserted mid-operation (count=2, stalled) -> next cycle all outputs at reset values; following push appears after 1 cycle.
